// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline freeze/bubble/flush sequencer for the 5-stage core.
// It resolves load-use hazards that forwarding cannot cover, flushes the pipe on
// taken branches, and holds EX while the multi-cycle mul/div unit is busy.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   ID_EX_mem_read      ID/EX instruction is a load
//   ID_EX_rt            load destination register in ID/EX
//   IF_ID_rs/IF_ID_rt   source registers of the IF/ID instruction
//   IF_ID_uses_rt       IF/ID instruction reads rt as a source
//   EX_branch_taken     branch/jump in EX resolved taken
//   ID_EX_md_start      mul/div entering EX
//   md_done             mul/div result valid
//   pc_write            PC load enable
//   IF_ID_write         IF/ID load enable
//   IF_ID_flush         clear IF/ID to NOP
//   ID_EX_bubble        zero control fields entering ID/EX
//   EX_hold             freeze ID/EX, block EX/MEM writes
//   md_go               one-cycle start pulse to the mul/div unit
//   md_timeout          sticky flag: a mul/div was force-released
//   stall_cycles        saturating count of cycles with pc_write=0
module hazard_stall_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_mem_read,
    input  logic [4:0]       ID_EX_rt,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_uses_rt,
    input  logic             EX_branch_taken,
    input  logic             ID_EX_md_start,
    input  logic             md_done,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             EX_hold,
    output logic             md_go,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WAIT_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              timeout_set;
    logic              lu;

    // Load-use hazard: a load's destination is needed by the very next instruction.
    assign lu = ID_EX_mem_read && (ID_EX_rt != 5'd0) &&
                ((ID_EX_rt == IF_ID_rs) || (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));

    // State and wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state and pipeline control; outputs are combinational so the stall
    // takes effect in the same cycle the hazard is seen.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        EX_hold      = 1'b0;
        md_go        = 1'b0;

        if (rst) begin
            // Keep the pipe quiet and filled with NOPs while held in reset.
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (EX_branch_taken) begin
                        IF_ID_flush  = 1'b1;
                        ID_EX_bubble = 1'b1;
                    end else if (ID_EX_md_start) begin
                        md_go        = 1'b1;
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        EX_hold      = 1'b1;
                        state_nxt    = MD_WAIT;
                        wait_cnt_nxt = '0;
                    end else if (lu) begin
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_bubble = 1'b1;
                    end
                end
                MD_WAIT: begin
                    pc_write    = 1'b0;
                    IF_ID_write = 1'b0;
                    EX_hold     = 1'b1;
                    if (md_done || (wait_cnt == WAIT_LAST)) begin
                        // Release in this cycle; flag it when the unit never answered.
                        pc_write    = 1'b1;
                        IF_ID_write = 1'b1;
                        EX_hold     = 1'b0;
                        state_nxt   = RUN;
                        timeout_set = !md_done;
                    end else begin
                        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Sticky timeout flag and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_timeout   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (timeout_set) begin
                md_timeout <= 1'b1;
            end
            if (!pc_write && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. Two instances share the stimulus: dut
// (long timeout, wide counter) and dut_t (MD_TIMEOUT=4, CNT_W=3) for the timeout
// and counter saturation cases.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst;
    logic       ID_EX_mem_read;
    logic [4:0] ID_EX_rt;
    logic [4:0] IF_ID_rs;
    logic [4:0] IF_ID_rt;
    logic       IF_ID_uses_rt;
    logic       EX_branch_taken;
    logic       ID_EX_md_start;
    logic       md_done;

    logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_hold, md_go, md_timeout;
    logic [15:0] stall_cycles;
    logic        pc_write_t, IF_ID_write_t, IF_ID_flush_t, ID_EX_bubble_t, EX_hold_t, md_go_t, md_timeout_t;
    logic [2:0]  stall_cycles_t;

    int n_vec = 0;
    int n_err = 0;

    hazard_stall_ctrl #(.MD_TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_rt(ID_EX_rt),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rt(IF_ID_uses_rt),
        .EX_branch_taken(EX_branch_taken), .ID_EX_md_start(ID_EX_md_start), .md_done(md_done),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_bubble(ID_EX_bubble), .EX_hold(EX_hold), .md_go(md_go),
        .md_timeout(md_timeout), .stall_cycles(stall_cycles)
    );

    hazard_stall_ctrl #(.MD_TIMEOUT(4), .CNT_W(3)) dut_t (
        .clk(clk), .rst(rst),
        .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_rt(ID_EX_rt),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rt(IF_ID_uses_rt),
        .EX_branch_taken(EX_branch_taken), .ID_EX_md_start(ID_EX_md_start), .md_done(md_done),
        .pc_write(pc_write_t), .IF_ID_write(IF_ID_write_t), .IF_ID_flush(IF_ID_flush_t),
        .ID_EX_bubble(ID_EX_bubble_t), .EX_hold(EX_hold_t), .md_go(md_go_t),
        .md_timeout(md_timeout_t), .stall_cycles(stall_cycles_t)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        ID_EX_mem_read  = 1'b0;
        ID_EX_rt        = 5'd0;
        IF_ID_rs        = 5'd0;
        IF_ID_rt        = 5'd0;
        IF_ID_uses_rt   = 1'b0;
        EX_branch_taken = 1'b0;
        ID_EX_md_start  = 1'b0;
        md_done         = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rt, input logic [4:0] rs,
                          input logic [4:0] if_rt, input logic uses_rt);
        ID_EX_mem_read = 1'b1;
        ID_EX_rt       = rt;
        IF_ID_rs       = rs;
        IF_ID_rt       = if_rt;
        IF_ID_uses_rt  = uses_rt;
    endtask

    // Cycle boundary: inputs change just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // Outputs forced while in reset
        sample();
        chk("rst_pc_write", 32'(pc_write), 32'd0);
        chk("rst_ifid_write", 32'(IF_ID_write), 32'd0);
        chk("rst_flush", 32'(IF_ID_flush), 32'd1);
        chk("rst_bubble", 32'(ID_EX_bubble), 32'd1);
        chk("rst_hold", 32'(EX_hold), 32'd0);
        chk("rst_md_go", 32'(md_go), 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        chk("rst_timeout", 32'(md_timeout), 32'd0);
        tick();
        rst = 1'b0;

        // Load-use on rs: one stall cycle, then normal flow
        set_lu(5'd5, 5'd5, 5'd0, 1'b0);
        sample();
        chk("lu_pc_write", 32'(pc_write), 32'd0);
        chk("lu_ifid_write", 32'(IF_ID_write), 32'd0);
        chk("lu_bubble", 32'(ID_EX_bubble), 32'd1);
        chk("lu_hold", 32'(EX_hold), 32'd0);
        chk("lu_flush", 32'(IF_ID_flush), 32'd0);
        tick();
        idle();
        sample();
        chk("lu_next_pc_write", 32'(pc_write), 32'd1);
        chk("lu_next_bubble", 32'(ID_EX_bubble), 32'd0);
        chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
        tick();

        // Load into $0 never stalls
        set_lu(5'd0, 5'd0, 5'd0, 1'b1);
        sample();
        chk("lu_r0_pc_write", 32'(pc_write), 32'd1);
        chk("lu_r0_bubble", 32'(ID_EX_bubble), 32'd0);
        tick();

        // rt match ignored unless rt is a source
        set_lu(5'd5, 5'd3, 5'd5, 1'b0);
        sample();
        chk("lu_rt_unused_pc", 32'(pc_write), 32'd1);
        tick();
        set_lu(5'd5, 5'd3, 5'd5, 1'b1);
        sample();
        chk("lu_rt_used_pc", 32'(pc_write), 32'd0);
        chk("lu_rt_used_bubble", 32'(ID_EX_bubble), 32'd1);
        tick();
        idle();
        sample();
        chk("lu_stall_cnt2", 32'(stall_cycles), 32'd2);
        tick();

        // Branch wins over mul/div start and load-use
        set_lu(5'd5, 5'd5, 5'd0, 1'b0);
        EX_branch_taken = 1'b1;
        ID_EX_md_start  = 1'b1;
        sample();
        chk("br_flush", 32'(IF_ID_flush), 32'd1);
        chk("br_bubble", 32'(ID_EX_bubble), 32'd1);
        chk("br_pc_write", 32'(pc_write), 32'd1);
        chk("br_ifid_write", 32'(IF_ID_write), 32'd1);
        chk("br_md_go", 32'(md_go), 32'd0);
        chk("br_hold", 32'(EX_hold), 32'd0);
        tick();
        idle();
        sample();
        chk("br_after_hold", 32'(EX_hold), 32'd0);
        chk("br_after_pc", 32'(pc_write), 32'd1);
        chk("br_after_stall", 32'(stall_cycles), 32'd2);
        tick();

        // md_done has no effect in RUN
        md_done = 1'b1;
        sample();
        chk("run_done_pc", 32'(pc_write), 32'd1);
        chk("run_done_hold", 32'(EX_hold), 32'd0);
        tick();

        // Mul/div released by md_done in cycle 5
        do_reset();
        ID_EX_md_start = 1'b1;
        sample();
        chk("md_c0_go", 32'(md_go), 32'd1);
        chk("md_c0_hold", 32'(EX_hold), 32'd1);
        chk("md_c0_pc", 32'(pc_write), 32'd0);
        tick();
        ID_EX_md_start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) begin
                EX_branch_taken = 1'b1;
            end else begin
                EX_branch_taken = 1'b0;
            end
            sample();
            chk("md_wait_go", 32'(md_go), 32'd0);
            chk("md_wait_hold", 32'(EX_hold), 32'd1);
            chk("md_wait_pc", 32'(pc_write), 32'd0);
            chk("md_wait_flush", 32'(IF_ID_flush), 32'd0);
            tick();
        end
        EX_branch_taken = 1'b0;
        md_done = 1'b1;
        sample();
        chk("md_c5_hold", 32'(EX_hold), 32'd0);
        chk("md_c5_pc", 32'(pc_write), 32'd1);
        chk("md_c5_ifid", 32'(IF_ID_write), 32'd1);
        tick();
        md_done = 1'b0;
        sample();
        chk("md_after_stall", 32'(stall_cycles), 32'd5);
        chk("md_after_hold", 32'(EX_hold), 32'd0);
        chk("md_after_timeout", 32'(md_timeout), 32'd0);
        tick();

        // Timeout on dut_t: forced release in cycle 4, flag from cycle 5
        do_reset();
        ID_EX_md_start = 1'b1;
        sample();
        chk("to_c0_go", 32'(md_go_t), 32'd1);
        tick();
        ID_EX_md_start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            sample();
            chk("to_wait_hold", 32'(EX_hold_t), 32'd1);
            tick();
        end
        sample();
        chk("to_c4_hold", 32'(EX_hold_t), 32'd0);
        chk("to_c4_pc", 32'(pc_write_t), 32'd1);
        chk("to_c4_flag", 32'(md_timeout_t), 32'd0);
        tick();
        sample();
        chk("to_c5_flag", 32'(md_timeout_t), 32'd1);
        chk("to_c5_hold", 32'(EX_hold_t), 32'd0);
        chk("to_c5_stall", 32'(stall_cycles_t), 32'd4);
        tick();
        ID_EX_md_start = 1'b1;
        sample();
        chk("to_md2_go", 32'(md_go_t), 32'd1);
        tick();
        ID_EX_md_start = 1'b0;
        md_done = 1'b1;
        sample();
        chk("to_md2_release", 32'(EX_hold_t), 32'd0);
        tick();
        md_done = 1'b0;
        sample();
        chk("to_flag_sticky", 32'(md_timeout_t), 32'd1);
        chk("to_md2_stall", 32'(stall_cycles_t), 32'd5);
        tick();

        // Reset in the middle of a wait
        ID_EX_md_start = 1'b1;
        tick();
        ID_EX_md_start = 1'b0;
        tick();
        sample();
        chk("rw_pre_hold", 32'(EX_hold), 32'd1);
        chk("rw_pre_hold_t", 32'(EX_hold_t), 32'd1);
        tick();
        rst = 1'b1;
        sample();
        chk("rw_pc", 32'(pc_write), 32'd0);
        chk("rw_flush", 32'(IF_ID_flush), 32'd1);
        chk("rw_bubble", 32'(ID_EX_bubble), 32'd1);
        chk("rw_hold", 32'(EX_hold), 32'd0);
        chk("rw_md_go", 32'(md_go), 32'd0);
        chk("rw_stall", 32'(stall_cycles), 32'd0);
        chk("rw_timeout_t", 32'(md_timeout_t), 32'd0);
        chk("rw_stall_t", 32'(stall_cycles_t), 32'd0);
        tick();
        rst = 1'b0;
        sample();
        chk("rw_after_pc", 32'(pc_write), 32'd1);
        chk("rw_after_hold", 32'(EX_hold), 32'd0);
        chk("rw_after_hold_t", 32'(EX_hold_t), 32'd0);
        tick();

        // Ten load-use cycles: 3-bit counter saturates at 7
        set_lu(5'd7, 5'd7, 5'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("sat_pc_t", 32'(pc_write_t), 32'd0);
            tick();
        end
        idle();
        sample();
        chk("sat_stall_t", 32'(stall_cycles_t), 32'd7);
        chk("sat_stall_wide", 32'(stall_cycles), 32'd10);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall sequencer for the 5-stage 32-bit MIPS core. It sits beside the EX-stage forwarding logic and decides when the pipeline freezes, bubbles or flushes. It covers load-use hazards that forwarding cannot resolve, taken-branch flushes, and multi-cycle mul/div occupancy of EX. It also counts stall cycles and flags a mul/div unit that never completes.

## Interface
- MD_TIMEOUT, 64, maximum MD_WAIT cycles before forced release (≥2)
- CNT_W, 16, width of stall_cycles counter

- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ID_EX_mem_read  in  1  instruction in ID/EX is a load
- ID_EX_rt  in  5  load destination register in ID/EX
- IF_ID_rs  in  5  rs of instruction in IF/ID
- IF_ID_rt  in  5  rt of instruction in IF/ID
- IF_ID_uses_rt  in  1  IF/ID instruction reads rt as a source
- EX_branch_taken  in  1  branch/jump in EX resolved taken
- ID_EX_md_start  in  1  ID/EX holds a mul/div entering EX
- md_done  in  1  mul/div unit result valid
- pc_write  out  1  PC register load enable
- IF_ID_write  out  1  IF/ID register load enable
- IF_ID_flush  out  1  clear IF/ID to NOP
- ID_EX_bubble  out  1  zero control fields entering ID/EX
- EX_hold  out  1  freeze ID/EX; no writes into EX/MEM
- md_go  out  1  one-cycle start pulse to the mul/div unit
- md_timeout  out  1  sticky: a mul/div was force-released
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

## Operation
- FSM states:
  - RUN: reset state.
  - MD_WAIT: mul/div occupying EX.
  - Wait counter: $clog2(MD_TIMEOUT+1) bits.
- Load-use hazard (lu) is defined as: ID_EX_mem_read && ID_EX_rt != 0 && (ID_EX_rt == IF_ID_rs || (IF_ID_uses_rt && ID_EX_rt == IF_ID_rt)).
- RUN outputs are combinational. Priority is branch > mul/div > load-use:
  - EX_branch_taken: pc_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=1, md_go=0. Any ID_EX_md_start in the same cycle is ignored.
  - else ID_EX_md_start: md_go=1, pc_write=0, IF_ID_write=0, EX_hold=1. Next state is MD_WAIT and the wait counter clears to 0. md_done in this cycle is ignored.
  - else lu: pc_write=0, IF_ID_write=0, ID_EX_bubble=1. Stays in RUN; the stall is inherently one cycle.
  - else: pc_write=1, IF_ID_write=1, all other outputs 0.
- MD_WAIT:
  - Default outputs: pc_write=0, IF_ID_write=0, EX_hold=1, ID_EX_bubble=0, IF_ID_flush=0, md_go=0.
  - EX_branch_taken, lu and ID_EX_md_start are ignored.
  - md_done=1: release in the same cycle (pc_write=1, IF_ID_write=1, EX_hold=0). Next state is RUN.
  - No md_done and wait counter == MD_TIMEOUT-1: release in the same cycle as above. Next state is RUN and md_timeout is set at the edge.
  - Otherwise the wait counter increments.
- md_timeout is sticky and cleared only by rst.
- stall_cycles increments at each edge where pc_write=0 and rst=0. It saturates at 2^CNT_W-1.

## Timing
- Reset asserted (asynchronous): state=RUN, wait counter=0, stall_cycles=0, md_timeout=0.
- While rst=1, outputs are forced to: pc_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_bubble=1, EX_hold=0, md_go=0.
- Reset in MD_WAIT aborts the wait; the first cycle after deassert is RUN.
- Load-use stall costs exactly 1 cycle; branch flush costs 2 squashed instructions and 0 frozen cycles.
- Mul/div stall length: md_go in cycle 0, MD_WAIT from cycle 1.
  - md_done at cycle k≥1 gives release in cycle k; total frozen cycles = k.
  - Forced release happens in cycle MD_TIMEOUT.
- md_go is exactly one cycle wide and never asserted outside RUN.
- No output depends on md_done while in RUN.

## Test plan
- Load-use:
  - lw $5 in ID/EX with IF_ID_rs=5 -> one cycle of pc_write=0, IF_ID_write=0, ID_EX_bubble=1. The next cycle has normal flow; stall_cycles=1.
  - Same with ID_EX_rt=0 -> no stall.
  - IF_ID_rt=5 with IF_ID_uses_rt=0 -> no stall.
- Branch: EX_branch_taken=1 together with lu=1 and ID_EX_md_start=1 -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, md_go=0; state stays RUN.
- Mul/div: ID_EX_md_start at cycle 0 -> md_go=1 only in cycle 0. md_done at cycle 5 -> EX_hold=1 in cycles 0-4 and 0 in cycle 5; stall_cycles=5.
- Timeout: MD_TIMEOUT=4 with md_done never asserted -> release in cycle 4, md_timeout=1 from cycle 5, state RUN. md_timeout stays 1 across a later normal mul/div.
- Reset mid-wait: assert rst in cycle 2 of MD_WAIT -> outputs forced immediately; stall_cycles=0, md_timeout=0. After deassert, normal flow resumes in RUN.
- Saturation: CNT_W=3 with 10 consecutive load-use stall cycles -> stall_cycles holds at 7.
